// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} pairs between fetch and decode.
// Optional zero-latency empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          Clk,
  input  logic          Clr_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_instr,
  output logic          in_ready,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_instr,
  input  logic          out_ready,
  output logic [AW:0]   count
);

  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          bypass;
  entry_t        head;

  // Status decodes from registered pointers only
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    count    = wr_ptr - rd_ptr;
    in_ready = !full;
  end

  // Handshake qualification and head presentation
  always_comb begin
    bypass = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty && in_valid && !flush;
`endif
    head      = mem[rd_ptr[AW-1:0]];
    out_valid = !empty || bypass;
    out_pc    = 32'h0;
    out_instr = 32'h0;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (!empty) begin
      out_pc    = head.pc;
      out_instr = head.instr;
    end
    // A bypassed entry consumed the same cycle is never written
    push = in_valid && !full && !flush && !(bypass && out_ready);
    pop  = !empty && out_ready && !flush;
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage carries no reset; occupancy is defined by the pointers alone
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{pc: in_pc, instr: in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// compared against a queue-based occupancy model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          Clk;
  logic          Clr_n;
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_ready;
  logic [AW:0]   count;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] model_q[$];

  fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk      (Clk),
    .Clr_n    (Clr_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .count    (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs against the model, then advance the model at posedge
  task automatic step(input logic fl, input logic iv, input logic [31:0] pc,
                      input logic [31:0] instr, input logic ordy);
    int n;
    logic byp;
    logic [63:0] head;
    flush = fl; in_valid = iv; in_pc = pc; in_instr = instr; out_ready = ordy;
    #1;
    n   = model_q.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (n == 0) && iv && !fl;
`endif
    head = byp ? {pc, instr} : ((n > 0) ? model_q[0] : 64'h0);
    chk("count",     64'(count),     64'(n));
    chk("in_ready",  64'(in_ready),  64'(n < DEPTH));
    chk("out_valid", 64'(out_valid), 64'((n > 0) || byp));
    chk("out_data",  {out_pc, out_instr}, head);
    @(posedge Clk);
    if (fl) model_q.delete();
    else begin
      if (n > 0 && ordy) void'(model_q.pop_front());
      if (iv && n < DEPTH && !(byp && ordy)) model_q.push_back({pc, instr});
    end
    @(negedge Clk);
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hA5C3_0F11;
  endfunction

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    Clr_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    @(negedge Clk); @(negedge Clk);
    Clr_n = 1'b1;
    @(negedge Clk);

    // Asynchronous reset mid-stream with three entries queued
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h2000 + 32'(4*i), ins(32'h2000 + 32'(4*i)), 1'b0);
    in_valid = 1'b0;
    #2;
    chk("pre_rst_count", 64'(count), 64'(3));
    Clr_n = 1'b0;
    #1;
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_out_pc", 64'(out_pc), 64'(0));
    model_q.delete();
    @(negedge Clk);
    Clr_n = 1'b1;
    @(negedge Clk);

    // Fill to full, refuse a fifth push, then drain in order
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h3000 + 32'(4*i), ins(32'h3000 + 32'(4*i)), 1'b0);
    step(1'b0, 1'b1, 32'h3010, ins(32'h3010), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Full with simultaneous pop: push refused, then accepted next cycle
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h4000 + 32'(4*i), ins(32'h4000 + 32'(4*i)), 1'b0);
    step(1'b0, 1'b1, 32'h4010, ins(32'h4010), 1'b1);
    step(1'b0, 1'b1, 32'h4010, ins(32'h4010), 1'b1);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    idle();

    // Wrap-around streaming at one push and one pop per cycle
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h3000 + 32'(4*i), ins(32'h3000 + 32'(4*i)), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Flush priority over push and pop
    step(1'b0, 1'b1, 32'h5000, ins(32'h5000), 1'b0);
    step(1'b0, 1'b1, 32'h5004, ins(32'h5004), 1'b0);
    step(1'b1, 1'b1, 32'h5008, ins(32'h5008), 1'b1);
    idle();
    idle();

    // Empty queue presented with a consuming decode
    step(1'b0, 1'b1, 32'h3010, ins(32'h3010), 1'b1);
    idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();

    // Random traffic
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      logic fl, iv, ordy;
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(fl, iv, pc, $urandom, ordy);
      pc = pc + 32'd4;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
